cdb_arbiter: RTL and testbench

//  Producer end of the common data bus (CDB). Collects completed results from
//  the execution units (ALU, MUL, DIV, LSU) and buffers one result per unit.

---
 rtl/cdb_arbiter.sv | 134 +++++++++++++
 tb/tb_cdb_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
//   Producer end of the common data bus. Each execution unit (0=ALU, 1=MUL,
//   2=DIV, 3=LSU) owns a one-entry holding slot. A round-robin arbiter picks
//   one full slot per cycle and drives it onto the registered CDB broadcast.
//   The register status table and issue queues snoop this broadcast for tag
//   wake-up and branch/jalr resolution.
//
// Ports
//   clk, rst            clock (rising edge), async active-high reset
//   flush               sync kill of all buffered results and the broadcast
//   src_valid/ready     per-source handshake; slot loads on valid & ready
//   src_data, src_tag   packed per source, source i at [i*W +: W]
//   src_branch, src_branch_taken, src_store_pc, src_jalr
//                       per-source flags, carried to the CDB unchanged
//   cdb_*               registered broadcast (data/tag/flags hold when idle)
//   grant_cnt           broadcasts since reset, wraps 0xFFFF -> 0
// ---------------------------------------------------------------------------
module cdb_arbiter #(
   parameter int NUM_SRC = 4,
   parameter int DATA_W  = 32,
   parameter int TAG_W   = 6
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic [NUM_SRC-1:0]        src_valid,
   output logic [NUM_SRC-1:0]        src_ready,
   input  logic [NUM_SRC*DATA_W-1:0] src_data,
   input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
   input  logic [NUM_SRC-1:0]        src_branch,
   input  logic [NUM_SRC-1:0]        src_branch_taken,
   input  logic [NUM_SRC-1:0]        src_store_pc,
   input  logic [NUM_SRC-1:0]        src_jalr,
   output logic                      cdb_valid,
   output logic [DATA_W-1:0]         cdb_data,
   output logic [TAG_W-1:0]          cdb_tag,
   output logic                      cdb_branch,
   output logic                      cdb_branch_taken,
   output logic                      cdb_store_pc,
   output logic                      cdb_jalr,
   output logic [15:0]               grant_cnt
);

   localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   // Slot flag bits: 0 branch, 1 branch_taken, 2 store_pc, 3 jalr
   logic [DATA_W-1:0]  slot_data  [NUM_SRC];
   logic [TAG_W-1:0]   slot_tag   [NUM_SRC];
   logic [3:0]         slot_flags [NUM_SRC];
   logic [NUM_SRC-1:0] hold_vld;

   logic [PTR_W-1:0]   rr_ptr;
   logic [PTR_W-1:0]   win_idx;
   logic [PTR_W-1:0]   next_ptr;
   logic               any_grant;
   logic [NUM_SRC-1:0] grant;
   logic [NUM_SRC-1:0] accept;

   // A slot being broadcast this cycle can be refilled at the same edge,
   // which is what lets a lone source stream one result per cycle.
   assign src_ready = {NUM_SRC{~flush}} & (~hold_vld | grant);
   assign accept    = src_valid & src_ready;

   // Round-robin search: start at rr_ptr, ascend with wrap, first full slot wins.
   always_comb begin
      int idx;
      // NOTE: every comb output gets a default before any conditional
      // assignment, so no path leaves a value unassigned (no latch).
      grant     = '0;
      win_idx   = '0;
      any_grant = 1'b0;
      idx       = 0;
      for (int k = 0; k < NUM_SRC; k++) begin
         idx = (int'(rr_ptr) + k) % NUM_SRC;
         if (!any_grant && hold_vld[idx]) begin
            any_grant = 1'b1;
            win_idx   = PTR_W'(idx);
         end
      end
      if (any_grant) grant[win_idx] = 1'b1;
   end

   assign next_ptr = (win_idx == PTR_W'(NUM_SRC - 1)) ? '0 : win_idx + PTR_W'(1);

   // NOTE: slot payload is storage qualified by hold_vld, so it carries no
   // reset; only the valid bits and control state are reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_SRC; i++) begin
         if (accept[i]) begin
            slot_data[i]  <= src_data[i*DATA_W +: DATA_W];
            slot_tag[i]   <= src_tag[i*TAG_W +: TAG_W];
            slot_flags[i] <= {src_jalr[i], src_store_pc[i],
                              src_branch_taken[i], src_branch[i]};
         end
      end
   end

   // NOTE: all state updates use non-blocking assignment so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_vld         <= '0;
         rr_ptr           <= '0;
         grant_cnt        <= '0;
         cdb_valid        <= 1'b0;
         cdb_data         <= '0;
         cdb_tag          <= '0;
         cdb_branch       <= 1'b0;
         cdb_branch_taken <= 1'b0;
         cdb_store_pc     <= 1'b0;
         cdb_jalr         <= 1'b0;
      end else if (flush) begin
         // Kill everything in flight; arbitration history is kept.
         hold_vld  <= '0;
         cdb_valid <= 1'b0;
      end else begin
         // Reload wins over the grant clear when both hit the same slot.
         hold_vld  <= (hold_vld & ~grant) | accept;
         cdb_valid <= any_grant;
         if (any_grant) begin
            cdb_data         <= slot_data[win_idx];
            cdb_tag          <= slot_tag[win_idx];
            cdb_branch       <= slot_flags[win_idx][0];
            cdb_branch_taken <= slot_flags[win_idx][1];
            cdb_store_pc     <= slot_flags[win_idx][2];
            cdb_jalr         <= slot_flags[win_idx][3];
            rr_ptr           <= next_ptr;
            grant_cnt        <= grant_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cdb_arbiter
//   Scoreboard bench for cdb_arbiter. Expected broadcasts are pushed in the
//   order the round-robin arbiter must grant them; a negedge monitor pops one
//   entry per cdb_valid cycle. Directed checks cover latency, ready, flush,
//   and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_cdb_arbiter;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int TW = 6;

   logic            clk = 1'b0;
   logic            rst;
   logic            flush;
   logic [N-1:0]    src_valid;
   logic [N-1:0]    src_ready;
   logic [N*DW-1:0] src_data;
   logic [N*TW-1:0] src_tag;
   logic [N-1:0]    src_branch;
   logic [N-1:0]    src_branch_taken;
   logic [N-1:0]    src_store_pc;
   logic [N-1:0]    src_jalr;
   logic            cdb_valid;
   logic [DW-1:0]   cdb_data;
   logic [TW-1:0]   cdb_tag;
   logic            cdb_branch;
   logic            cdb_branch_taken;
   logic            cdb_store_pc;
   logic            cdb_jalr;
   logic [15:0]     grant_cnt;

   int n_vec = 0;
   int n_bad = 0;
   logic [63:0] exp_q [$];
   logic [63:0] mon_exp;

   cdb_arbiter #(.NUM_SRC(N), .DATA_W(DW), .TAG_W(TW)) dut (
      .clk              (clk),
      .rst              (rst),
      .flush            (flush),
      .src_valid        (src_valid),
      .src_ready        (src_ready),
      .src_data         (src_data),
      .src_tag          (src_tag),
      .src_branch       (src_branch),
      .src_branch_taken (src_branch_taken),
      .src_store_pc     (src_store_pc),
      .src_jalr         (src_jalr),
      .cdb_valid        (cdb_valid),
      .cdb_data         (cdb_data),
      .cdb_tag          (cdb_tag),
      .cdb_branch       (cdb_branch),
      .cdb_branch_taken (cdb_branch_taken),
      .cdb_store_pc     (cdb_store_pc),
      .cdb_jalr         (cdb_jalr),
      .grant_cnt        (grant_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Flags packed {jalr, store_pc, branch_taken, branch}
   function automatic logic [63:0] pack(input logic [31:0] d, input logic [5:0] t,
                                        input logic [3:0] f);
      return {22'd0, f, t, d};
   endfunction

   // Scoreboard monitor: every broadcast must match the next expected entry.
   always @(negedge clk) begin
      if (rst === 1'b0 && cdb_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("cdb_spurious", 64'(cdb_valid), 64'd0);
         end else begin
            mon_exp = exp_q.pop_front();
            check("cdb_result",
                  pack(cdb_data, cdb_tag,
                       {cdb_jalr, cdb_store_pc, cdb_branch_taken, cdb_branch}),
                  mon_exp);
         end
      end
   end

   task automatic idle_inputs();
      src_valid        = '0;
      src_data         = '0;
      src_tag          = '0;
      src_branch       = '0;
      src_branch_taken = '0;
      src_store_pc     = '0;
      src_jalr         = '0;
      flush            = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      exp_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Present a result on source i; push it to the scoreboard when expected.
   task automatic drive_src(input int i, input logic [31:0] d, input logic [5:0] t,
                            input logic [3:0] f, input bit expect_it);
      src_valid[i]          = 1'b1;
      src_data[i*DW +: DW]  = d;
      src_tag[i*TW +: TW]   = t;
      src_branch[i]         = f[0];
      src_branch_taken[i]   = f[1];
      src_store_pc[i]       = f[2];
      src_jalr[i]           = f[3];
      if (expect_it) exp_q.push_back(pack(d, t, f));
   endtask

   task automatic wait_drain(input string tag);
      for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
      check(tag, 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      int  idx1;
      bit  acc;

      // ---- reset state ----
      do_reset();
      check("rst_valid", 64'(cdb_valid), 64'd0);
      check("rst_data",  64'(cdb_data), 64'd0);
      check("rst_tag",   64'(cdb_tag), 64'd0);
      check("rst_flags", 64'({cdb_jalr, cdb_store_pc, cdb_branch_taken, cdb_branch}), 64'd0);
      check("rst_cnt",   64'(grant_cnt), 64'd0);
      check("rst_ready", 64'(src_ready), 64'hF);

      // ---- 1: single source latency ----
      next_cycle();
      drive_src(0, 32'h24, 6'd9, 4'b0000, 1'b1);
      @(negedge clk);
      check("t1_pre", 64'(cdb_valid), 64'd0);
      next_cycle();
      idle_inputs();
      @(negedge clk);
      check("t1_wait", 64'(cdb_valid), 64'd0);
      next_cycle();
      @(negedge clk);
      check("t1_valid", 64'(cdb_valid), 64'd1);
      check("t1_tag",   64'(cdb_tag), 64'd9);
      check("t1_data",  64'(cdb_data), 64'h24);
      next_cycle();
      @(negedge clk);
      check("t1_drop", 64'(cdb_valid), 64'd0);
      check("t1_cnt",  64'(grant_cnt), 64'd1);
      wait_drain("t1_drain");

      // ---- 2: all sources at once, round-robin from 0 ----
      do_reset();
      next_cycle();
      for (int i = 0; i < N; i++) drive_src(i, 32'h100 + i, 6'(i + 1), 4'b0000, 1'b1);
      next_cycle();
      idle_inputs();
      @(negedge clk);
      check("t2_wait", 64'(cdb_valid), 64'd0);
      for (int k = 0; k < N; k++) begin
         next_cycle();
         @(negedge clk);
         check("t2_valid", 64'(cdb_valid), 64'd1);
         check("t2_tag",   64'(cdb_tag), 64'(k + 1));
      end
      next_cycle();
      @(negedge clk);
      check("t2_idle", 64'(cdb_valid), 64'd0);
      check("t2_cnt",  64'(grant_cnt), 64'd4);
      // Pointer wrapped to 0: source 0 must beat source 3.
      next_cycle();
      drive_src(0, 32'hA0, 6'd10, 4'b0000, 1'b1);
      drive_src(3, 32'hA3, 6'd13, 4'b0000, 1'b1);
      next_cycle();
      idle_inputs();
      wait_drain("t2_drain");
      check("t2_cnt2", 64'(grant_cnt), 64'd6);

      // ---- 3: src1 streams, src3 sneaks in ----
      do_reset();
      idx1 = 0;
      next_cycle();
      drive_src(1, 32'h1000, 6'd30, 4'b0000, 1'b1);
      drive_src(3, 32'h3333, 6'd33, 4'b0000, 1'b1);
      for (int c = 0; idx1 < 6 && c < 20; c++) begin
         @(negedge clk);
         check("t3_ready1", 64'(src_ready[1]), 64'(c != 2));
         acc = src_ready[1];
         next_cycle();
         src_valid[3] = 1'b0;
         if (acc) begin
            idx1++;
            if (idx1 < 6) drive_src(1, 32'h1000 + idx1, 6'(30 + idx1), 4'b0000, 1'b1);
            else          src_valid[1] = 1'b0;
         end
      end
      check("t3_sent", 64'(idx1), 64'd6);
      wait_drain("t3_drain");

      // ---- 4: flag pass-through, tag 0 ordinary ----
      do_reset();
      next_cycle();
      drive_src(1, 32'h8000_0040, 6'd0,  4'b1000, 1'b1);
      drive_src(2, 32'h0000_0ABC, 6'd21, 4'b0011, 1'b1);
      drive_src(3, 32'h3054,      6'd7,  4'b0100, 1'b1);
      next_cycle();
      idle_inputs();
      wait_drain("t4_drain");

      // ---- 5: flush with all slots full ----
      do_reset();
      next_cycle();
      for (int i = 0; i < N; i++) drive_src(i, 32'h500 + i, 6'(40 + i), 4'b0000, 1'b0);
      next_cycle();
      flush = 1'b1;
      @(negedge clk);
      check("t5_ready_flush", 64'(src_ready), 64'd0);
      next_cycle();
      idle_inputs();
      @(negedge clk);
      check("t5_valid", 64'(cdb_valid), 64'd0);
      check("t5_ready_after", 64'(src_ready), 64'hF);
      repeat (6) next_cycle();
      check("t5_cnt", 64'(grant_cnt), 64'd0);
      drive_src(3, 32'h5003, 6'd53, 4'b0000, 1'b0);
      drive_src(0, 32'h5000, 6'd50, 4'b0000, 1'b1);
      exp_q.push_back(pack(32'h5003, 6'd53, 4'b0000));
      next_cycle();
      idle_inputs();
      wait_drain("t5_drain");

      // ---- 6: async reset mid-stream ----
      do_reset();
      next_cycle();
      drive_src(0, 32'h600, 6'd60, 4'b0000, 1'b1);
      for (int i = 1; i < N; i++) drive_src(i, 32'h600 + i, 6'(60 + i), 4'b0000, 1'b0);
      next_cycle();
      idle_inputs();
      @(posedge clk);
      #7;
      rst = 1'b1;
      #1;
      check("t6_valid", 64'(cdb_valid), 64'd0);
      check("t6_cnt",   64'(grant_cnt), 64'd0);
      check("t6_ready", 64'(src_ready), 64'hF);
      @(posedge clk);
      #3;
      rst = 1'b0;
      repeat (6) @(negedge clk);
      check("t6_idle",  64'(cdb_valid), 64'd0);
      check("t6_cnt2",  64'(grant_cnt), 64'd0);
      check("t6_sb",    64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
